// File: rtl/instr_load_if.sv
// Field-set stream into the loader and the instruction-memory write port out of it.
interface instr_load_if #(
  parameter int WIDTH     = 16,
  parameter int IMM_BITS  = 8,
  parameter int OP_BITS   = 4,
  parameter int REG_BITS  = 4,
  parameter int ADDR_BITS = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic                 use_imm;
  logic [OP_BITS-1:0]   op_code;
  logic [OP_BITS-1:0]   ext_op_code;
  logic [REG_BITS-1:0]  A_index;
  logic [REG_BITS-1:0]  B_index;
  logic [IMM_BITS-1:0]  immediate_value;
  logic                 mem_ready;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [WIDTH-1:0]     mem_data;

  modport master (
    output in_valid, in_last, use_imm, op_code, ext_op_code, A_index, B_index,
           immediate_value, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  in_valid, in_last, use_imm, op_code, ext_op_code, A_index, B_index,
           immediate_value, mem_ready,
    output in_ready, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/instr_encode_loader.sv
// Re-encodes decoded instruction fields into 16-bit words, buffers them in a small
// FIFO and streams them into instruction memory at consecutive addresses.
module instr_encode_loader #(
  parameter int WIDTH      = 16,
  parameter int IMM_BITS   = 8,
  parameter int OP_BITS    = 4,
  parameter int REG_BITS   = 4,
  parameter int ADDR_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] start_addr,
  instr_load_if.slave          bus,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS:0]   words_written
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE_S} state_t;

  state_t               state;
  logic [WIDTH-1:0]     fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;
  logic                 last_pending;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  function automatic logic [WIDTH-1:0] encode_word(
    input logic [OP_BITS-1:0]  op,
    input logic [REG_BITS-1:0] a_idx,
    input logic [OP_BITS-1:0]  ext,
    input logic [REG_BITS-1:0] b_idx,
    input logic [IMM_BITS-1:0] imm,
    input logic                imm_form
  );
    return imm_form ? {op, a_idx, imm} : {op, a_idx, ext, b_idx};
  endfunction

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // After in_last is taken the session is closed to further field sets.
  assign bus.in_ready = (state == ACTIVE) && !last_pending && !full;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == ACTIVE) && !empty && bus.mem_ready;

  assign busy = (state == ACTIVE);
  assign done = (state == DONE_S);

  // Buffer storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wr_ptr] <= encode_word(bus.op_code, bus.A_index, bus.ext_op_code,
                                    bus.B_index, bus.immediate_value, bus.use_imm);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      last_pending  <= 1'b0;
      addr_q        <= '0;
      words_written <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.mem_we <= 1'b0;
          if (start) begin
            addr_q        <= start_addr;
            words_written <= '0;
            last_pending  <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            state         <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (bus.in_last)
              last_pending <= 1'b1;
          end
          if (pop) begin
            rd_ptr        <= rd_ptr + 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= addr_q;
            bus.mem_data  <= fifo_q[rd_ptr];
            addr_q        <= addr_q + 1'b1;
            words_written <= words_written + 1'b1;
          end else begin
            bus.mem_we <= 1'b0;
          end
          case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
          endcase
          // Push is impossible once last_pending is set, so this pop empties the FIFO.
          if (pop && last_pending && (count == ONE_CNT))
            state <= DONE_S;
        end
        DONE_S: begin
          bus.mem_we <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          bus.mem_we <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule
